// File: rtl/regfile_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ozone_wb_pkg
// Shared definitions for the register-file writeback arbiter: register
// address width, datapath width, the queued writeback request record and the
// hard-wired zero register address.
// ---------------------------------------------------------------------------
package ozone_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    // Writes addressed here are dropped on every path.
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles every non-clock/reset signal of the writeback arbiter:
//   alu_we/alu_rd/alu_data            ALU writeback (never stalled)
//   lng_valid/lng_ready/lng_rd/lng_data long-latency valid/ready handshake
//   chk_rs/chk_rt -> pend_rs/pend_rt  decode pending-write checks
//   fifo_count                        long-latency queue occupancy
//   RegWrite/WriteRegister/WriteData  registered regfile write port
// master: the producers/consumers around the arbiter. slave: the arbiter.
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
);
    import ozone_wb_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  alu_we;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;

    logic                  lng_valid;
    logic                  lng_ready;
    logic [REG_ADDR_W-1:0] lng_rd;
    logic [XLEN-1:0]       lng_data;

    logic [REG_ADDR_W-1:0] chk_rs;
    logic [REG_ADDR_W-1:0] chk_rt;
    logic                  pend_rs;
    logic                  pend_rt;

    logic [CNT_W-1:0]      fifo_count;

    logic                  RegWrite;
    logic [REG_ADDR_W-1:0] WriteRegister;
    logic [XLEN-1:0]       WriteData;

    modport master (
        output alu_we, alu_rd, alu_data,
        output lng_valid, lng_rd, lng_data,
        output chk_rs, chk_rt,
        input  lng_ready, pend_rs, pend_rt, fifo_count,
        input  RegWrite, WriteRegister, WriteData
    );

    modport slave (
        input  alu_we, alu_rd, alu_data,
        input  lng_valid, lng_rd, lng_data,
        input  chk_rs, chk_rt,
        output lng_ready, pend_rs, pend_rt, fifo_count,
        output RegWrite, WriteRegister, WriteData
    );

endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Circular queue of DEPTH writeback requests for the long-latency path.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   push, push_req    enqueue request (caller guarantees !full)
//   pop               dequeue head (caller guarantees !empty)
//   kill, kill_rd     clear valid of every entry (and the incoming push)
//                     whose rd equals kill_rd; the slot stays occupied
//   chk_a, chk_b      register numbers compared against every valid entry
//   head              current head entry
//   count/empty/full  occupancy
//   match_a, match_b  per-entry "valid and rd == chk" vectors
// Only the valid bits and pointers are reset; rd/data are plain storage.
// ---------------------------------------------------------------------------
module wb_fifo
    import ozone_wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_req_t               push_req,
    input  logic                  pop,
    input  logic                  kill,
    input  logic [REG_ADDR_W-1:0] kill_rd,
    input  logic [REG_ADDR_W-1:0] chk_a,
    input  logic [REG_ADDR_W-1:0] chk_b,
    output wb_req_t               head,
    output logic [CNT_W-1:0]      count,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH-1:0]      match_a,
    output logic [DEPTH-1:0]      match_b
);

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
    logic [REG_ADDR_W-1:0] rd_d   [DEPTH];
    logic [XLEN-1:0]       data_q [DEPTH];
    logic [XLEN-1:0]       data_d [DEPTH];

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign head  = '{valid: valid_q[head_q], rd: rd_q[head_q], data: data_q[head_q]};

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match_a[i] = valid_q[i] && (rd_q[i] == chk_a);
            match_b[i] = valid_q[i] && (rd_q[i] == chk_b);
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        rd_d    = rd_q;
        data_d  = data_q;

        if (kill) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_q[i] == kill_rd) begin
                    valid_d[i] = 1'b0;
                end
            end
        end

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end

        // A push that the same-edge ALU write supersedes lands already dead.
        if (push) begin
            valid_d[tail_q] = push_req.valid && !(kill && (push_req.rd == kill_rd));
            rd_d[tail_q]    = push_req.rd;
            data_d[tail_q]  = push_req.data;
            tail_d          = tail_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_q   <= rd_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Drives the register file's single write port from the ALU pipeline
// (absolute priority) and a queue of long-latency results, and reports
// whether decode source registers still have a write in flight.
// Ports:
//   clk   clock, all state on the rising edge
//   rst   asynchronous active-low reset
//   bus   regfile_wb_arbiter_if.slave (ALU path, long-latency handshake,
//         pending checks, fifo_count, registered RegWrite/WriteRegister/
//         WriteData)
// Build option: define WB_WAW_KILL_EN to have an ALU write invalidate queued
// long-latency writes to the same register, so the younger ALU value wins.
// XLEN must match ozone_wb_pkg::XLEN since queued entries use wb_req_t.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
    import ozone_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = ozone_wb_pkg::XLEN
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_req_t               head;
    wb_req_t               push_req;
    logic [CNT_W-1:0]      count;
    logic                  empty;
    logic                  full;
    logic [DEPTH-1:0]      match_rs;
    logic [DEPTH-1:0]      match_rt;
    logic                  alu_take;
    logic                  push;
    logic                  pop;
    logic                  kill;

    logic                  reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0] write_register_q, write_register_d;
    logic [XLEN-1:0]       write_data_q, write_data_d;

    assign alu_take = bus.alu_we && (bus.alu_rd != REG_ZERO);

    // Ready depends on occupancy only: a full queue refuses a push even when
    // the head drains on the same edge.
    assign bus.lng_ready = ~full;

    // Register-zero results still complete the handshake but are not stored.
    assign push     = bus.lng_valid && ~full && (bus.lng_rd != REG_ZERO);
    assign pop      = ~alu_take && ~empty;
    assign push_req = '{valid: 1'b1, rd: bus.lng_rd, data: bus.lng_data};

`ifdef WB_WAW_KILL_EN
    assign kill = alu_take;
`else
    assign kill = 1'b0;
`endif

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_req (push_req),
        .pop      (pop),
        .kill     (kill),
        .kill_rd  (bus.alu_rd),
        .chk_a    (bus.chk_rs),
        .chk_b    (bus.chk_rt),
        .head     (head),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .match_a  (match_rs),
        .match_b  (match_rt)
    );

    assign bus.fifo_count = count;

    // A write is pending until it has left the output stage.
    assign bus.pend_rs = (bus.chk_rs != REG_ZERO) &&
                         ((|match_rs) || (reg_write_q && (write_register_q == bus.chk_rs)));
    assign bus.pend_rt = (bus.chk_rt != REG_ZERO) &&
                         ((|match_rt) || (reg_write_q && (write_register_q == bus.chk_rt)));

    // Output stage: ALU first, otherwise the queue head. A killed head uses
    // its pop slot but does not write.
    always_comb begin
        reg_write_d      = 1'b0;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        if (alu_take) begin
            reg_write_d      = 1'b1;
            write_register_d = bus.alu_rd;
            write_data_d     = bus.alu_data;
        end else if (pop) begin
            reg_write_d      = head.valid;
            write_register_d = head.rd;
            write_data_d     = head.data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q      <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
        end else begin
            reg_write_q      <= reg_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
        end
    end

    assign bus.RegWrite      = reg_write_q;
    assign bus.WriteRegister = write_register_q;
    assign bus.WriteData     = write_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    import ozone_wb_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DEPTH(DEPTH), .XLEN(32)) bus ();

    regfile_wb_arbiter #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queue of outstanding long-latency writes plus the
    // contents of the regfile write port for the current cycle.
    typedef struct {
        bit          valid;
        int          rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    bit          m_we;
    int          m_rd;
    logic [31:0] m_data;
    bit          kill_mode;
    logic [31:0] rd3_writes[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_pend(input int r);
        if (r == 0) return 1'b0;
        if (m_we && m_rd == r) return 1'b1;
        foreach (mq[i]) if (mq[i].valid && mq[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_in(input bit awe, input int ard, input logic [31:0] ad,
                          input bit lv, input int lrd, input logic [31:0] ld);
        bus.alu_we    = awe;
        bus.alu_rd    = 5'(ard);
        bus.alu_data  = ad;
        bus.lng_valid = lv;
        bus.lng_rd    = 5'(lrd);
        bus.lng_data  = ld;
    endtask

    // Inputs are set while clk is low; check combinational outputs, advance
    // the model across the rising edge, then check the write port.
    task automatic cycle();
        bit          alu, xfer, kill;
        int          ard, lrd;
        logic [31:0] adata, ldata;
        ent_t        h, e;
        #1;
        chk("lng_ready", bus.lng_ready, 64'(mq.size() != DEPTH));
        chk("fifo_count", bus.fifo_count, 64'(mq.size()));
        chk("pend_rs", bus.pend_rs, 64'(m_pend(int'(bus.chk_rs))));
        chk("pend_rt", bus.pend_rt, 64'(m_pend(int'(bus.chk_rt))));
        ard   = int'(bus.alu_rd);
        adata = bus.alu_data;
        lrd   = int'(bus.lng_rd);
        ldata = bus.lng_data;
        alu   = bus.alu_we && ard != 0;
        xfer  = bus.lng_valid && (mq.size() != DEPTH);
        kill  = kill_mode && alu;
        @(posedge clk);
        if (alu) begin
            m_we = 1; m_rd = ard; m_data = adata;
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            m_we = h.valid; m_rd = h.rd; m_data = h.data;
        end else begin
            m_we = 0;
        end
        if (kill) foreach (mq[i]) if (mq[i].rd == ard) mq[i].valid = 0;
        if (xfer && lrd != 0) begin
            e.valid = !(kill && lrd == ard);
            e.rd    = lrd;
            e.data  = ldata;
            mq.push_back(e);
        end
        @(negedge clk);
        chk("RegWrite", bus.RegWrite, 64'(m_we));
        if (m_we) begin
            chk("WriteRegister", bus.WriteRegister, 64'(m_rd));
            chk("WriteData", bus.WriteData, 64'(m_data));
        end
        if (bus.RegWrite === 1'b1 && bus.WriteRegister == 5'd3) rd3_writes.push_back(bus.WriteData);
    endtask

    initial begin
        bit held;
        bit pre;
`ifdef WB_WAW_KILL_EN
        kill_mode = 1;
`else
        kill_mode = 0;
`endif
        mq.delete();
        m_we = 0; m_rd = 0; m_data = '0;

        // Reset state
        rst = 1'b0;
        set_in(0, 0, '0, 0, 0, '0);
        bus.chk_rs = 5'd5;
        bus.chk_rt = 5'd5;
        @(negedge clk);
        chk("rst_RegWrite", bus.RegWrite, 0);
        chk("rst_WriteRegister", bus.WriteRegister, 0);
        chk("rst_WriteData", bus.WriteData, 0);
        chk("rst_fifo_count", bus.fifo_count, 0);
        chk("rst_lng_ready", bus.lng_ready, 1);
        chk("rst_pend_rs", bus.pend_rs, 0);
        chk("rst_pend_rt", bus.pend_rt, 0);
        @(negedge clk);
        rst = 1'b1;

        // ALU only
        set_in(1, 5, 32'hDEADBEEF, 0, 0, '0);
        cycle();
        chk("alu_we", bus.RegWrite, 1);
        chk("alu_rd", bus.WriteRegister, 5);
        chk("alu_data", bus.WriteData, 32'hDEADBEEF);
        set_in(0, 0, '0, 0, 0, '0);
        cycle();
        chk("alu_idle", bus.RegWrite, 0);

        // Long path, idle
        set_in(0, 0, '0, 1, 7, 32'h1234);
        cycle();
        chk("lng_count1", bus.fifo_count, 1);
        chk("lng_nowrite", bus.RegWrite, 0);
        set_in(0, 0, '0, 0, 0, '0);
        cycle();
        chk("lng_we", bus.RegWrite, 1);
        chk("lng_rd", bus.WriteRegister, 7);
        chk("lng_data", bus.WriteData, 32'h1234);
        chk("lng_count0", bus.fifo_count, 0);
        cycle();

        // Full and backpressure
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, 1, $urandom, 1, 10 + i, 32'h100 + i);
            cycle();
        end
        set_in(1, 1, $urandom, 0, 0, '0);
        chk("full_count", bus.fifo_count, DEPTH);
        chk("full_ready", bus.lng_ready, 0);
        cycle();
        set_in(0, 0, '0, 0, 0, '0);
        for (int i = 0; i < DEPTH; i++) begin
            cycle();
            chk("drain_we", bus.RegWrite, 1);
            chk("drain_rd", bus.WriteRegister, 10 + i);
            chk("drain_data", bus.WriteData, 32'h100 + i);
        end
        cycle();

        // Register zero on both paths
        set_in(1, 0, 32'h5555, 1, 0, 32'h6666);
        cycle();
        chk("zero_we", bus.RegWrite, 0);
        chk("zero_count", bus.fifo_count, 0);
        set_in(0, 0, '0, 0, 0, '0);
        cycle();
        chk("zero_we2", bus.RegWrite, 0);

        // Pending
        bus.chk_rs = 5'd9;
        bus.chk_rt = 5'd0;
        set_in(1, 2, 32'h22, 1, 9, 32'h99);
        cycle();
        chk("pend_queued", bus.pend_rs, 1);
        set_in(1, 2, 32'h23, 0, 0, '0);
        cycle();
        chk("pend_held", bus.pend_rs, 1);
        set_in(0, 0, '0, 0, 0, '0);
        cycle();
        chk("pend_stage_we", bus.RegWrite, 1);
        chk("pend_stage_rd", bus.WriteRegister, 9);
        chk("pend_stage", bus.pend_rs, 1);
        cycle();
        chk("pend_clear", bus.pend_rs, 0);
        chk("pend_rt_zero", bus.pend_rt, 0);

        // WAW kill
        rd3_writes.delete();
        set_in(1, 4, 32'h44, 1, 3, 32'hAAAA);
        cycle();
        set_in(1, 3, 32'hBBBB, 0, 0, '0);
        cycle();
        set_in(0, 0, '0, 0, 0, '0);
        for (int i = 0; i < 3; i++) cycle();
        if (kill_mode) begin
            chk("waw_kill_n", rd3_writes.size(), 1);
            if (rd3_writes.size() >= 1) chk("waw_kill_0", rd3_writes[0], 32'hBBBB);
        end else begin
            chk("waw_n", rd3_writes.size(), 2);
            if (rd3_writes.size() >= 2) begin
                chk("waw_0", rd3_writes[0], 32'hBBBB);
                chk("waw_1", rd3_writes[1], 32'hAAAA);
            end
        end

        // Randomized traffic against the model, with one asynchronous reset
        held = 0;
        for (int k = 0; k < 400; k++) begin
            if (k == 200) begin
                rst = 1'b0;
                #1;
                chk("midrst_RegWrite", bus.RegWrite, 0);
                chk("midrst_count", bus.fifo_count, 0);
                chk("midrst_ready", bus.lng_ready, 1);
                mq.delete();
                m_we = 0;
                held = 0;
                @(negedge clk);
                rst = 1'b1;
            end
            bus.alu_we   = ($urandom_range(0, 99) < 55);
            bus.alu_rd   = 5'($urandom_range(0, 7));
            bus.alu_data = $urandom;
            if (!held) begin
                bus.lng_valid = ($urandom_range(0, 99) < 50);
                bus.lng_rd    = 5'($urandom_range(0, 7));
                bus.lng_data  = $urandom;
            end
            bus.chk_rs = 5'($urandom_range(0, 7));
            bus.chk_rt = 5'($urandom_range(0, 7));
            pre = bus.lng_valid && !bus.lng_ready;
            cycle();
            held = pre;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
